// File: rtl/reg_stim_sequencer.sv
// Clocked stimulus sequencer for the SD host register file: address sweeps,
// deterministic write data with read-back checking, and command-event stimulus.
module reg_stim_sequencer #(
    parameter int                ADR_W     = 5,
    parameter int                DATA_W    = 128,
    parameter int                STAT_W    = 16,
    parameter int                ADR_FIRST = 0,
    parameter int                ADR_LAST  = 15,
    parameter int                CMD_ADR   = 15,
    parameter int                GAP       = 2,
    parameter int                DATA_STEP = 2,
    parameter logic [DATA_W-1:0] RESP_STEP = 128'ha3157934b95c7a64789213fd456e,
    parameter int                ERR_STEP  = 7,
    parameter int                NORM_STEP = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADR_W-1:0]  adr_i,
    output logic              reg_write_en,
    output logic              reg_read_en,
    output logic [DATA_W-1:0] data_i,
    output logic              command_complete,
    output logic [DATA_W-1:0] response_i,
    output logic [STAT_W-1:0] error_interrupt_status_i,
    output logic [STAT_W-1:0] normal_interrupt_status_i,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count,
    output logic [ADR_W-1:0]  first_fail_adr
);

    typedef enum logic [2:0] {
        IDLE, WR, WGAP, RD, RWAIT, RGAP, FIN
    } state_t;

    localparam int GW = $clog2(GAP + 2);
    localparam logic [ADR_W-1:0] A_FIRST = ADR_W'(ADR_FIRST);
    localparam logic [ADR_W-1:0] A_LAST  = ADR_W'(ADR_LAST);
    localparam logic [ADR_W-1:0] A_CMD   = ADR_W'(CMD_ADR);
    localparam logic [GW-1:0]    G_END   = GW'((GAP > 0) ? GAP - 1 : 0);

    function automatic logic [DATA_W-1:0] pattern(
        input logic [DATA_W-1:0] s,
        input logic [ADR_W-1:0]  a
    );
        return s + DATA_W'(a) * DATA_W'(DATA_STEP);
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                stop_q, stop_d;
    logic [DATA_W-1:0]   data_q;
    logic                cmd_q;
    logic [DATA_W-1:0]   resp_q;
    logic [STAT_W-1:0]   err_stat_q, norm_stat_q;
    logic [7:0]          err_cnt_q;
    logic [ADR_W-1:0]    ff_adr_q;
    logic                wr_end, rd_end, at_last, cmd_ev, miss;

    assign at_last = (adr_q == A_LAST);
    assign cmd_ev  = (adr_q == A_CMD) &&
                     ((state_q == WR) || (state_q == RD && mode_q == 2'b01));
    assign miss    = (state_q == RWAIT) && mode_q[1] &&
                     (rd_data_i != pattern(seed_q, adr_q));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        adr_d   = adr_q;
        seed_d  = seed_q;
        gap_d   = gap_q;
        stop_d  = stop_q | stop;
        wr_end  = 1'b0;
        rd_end  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stop_d = start & stop;
                if (start) begin
                    mode_d  = mode;
                    seed_d  = '0;
                    adr_d   = A_FIRST;
                    gap_d   = '0;
                    state_d = (mode == 2'b01) ? RD : WR;
                end
            end
            WR: begin
                gap_d = '0;
                if (GAP == 0) wr_end = 1'b1;
                else          state_d = WGAP;
            end
            WGAP: begin
                if (gap_q == G_END) wr_end = 1'b1;
                else                gap_d  = gap_q + 1'b1;
            end
            RD: state_d = RWAIT;
            RWAIT: begin
                gap_d = '0;
                if (GAP == 0) rd_end = 1'b1;
                else          state_d = RGAP;
            end
            RGAP: begin
                if (gap_q == G_END) rd_end = 1'b1;
                else                gap_d  = gap_q + 1'b1;
            end
            FIN: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pending stop wins over the pass-end decision once the access retires.
        if (wr_end) begin
            if (stop_d) begin
                state_d = FIN;
            end else if (at_last) begin
                if (mode_q == 2'b00) begin
                    state_d = FIN;
                end else begin
                    state_d = RD;
                    adr_d   = A_FIRST;
                end
            end else begin
                state_d = WR;
                adr_d   = adr_q + 1'b1;
            end
        end
        if (rd_end) begin
            if (stop_d) begin
                state_d = FIN;
            end else if (at_last) begin
                if (mode_q == 2'b11) begin
                    state_d = WR;
                    adr_d   = A_FIRST;
                    seed_d  = seed_q + 1'b1;
                end else begin
                    state_d = FIN;
                end
            end else begin
                state_d = RD;
                adr_d   = adr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            adr_q       <= A_FIRST;
            seed_q      <= '0;
            gap_q       <= '0;
            stop_q      <= 1'b0;
            data_q      <= '0;
            cmd_q       <= 1'b0;
            resp_q      <= '0;
            err_stat_q  <= '0;
            norm_stat_q <= '0;
            err_cnt_q   <= '0;
            ff_adr_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            adr_q   <= adr_d;
            seed_q  <= seed_d;
            gap_q   <= gap_d;
            stop_q  <= stop_d;
            if (state_d == WR) data_q <= pattern(seed_d, adr_d);
            cmd_q <= cmd_ev;
            if (cmd_ev) begin
                resp_q      <= resp_q + RESP_STEP;
                err_stat_q  <= err_stat_q + STAT_W'(ERR_STEP);
                norm_stat_q <= norm_stat_q + STAT_W'(NORM_STEP);
            end
            if (state_q == IDLE && start) begin
                err_cnt_q <= '0;
            end else if (miss) begin
                if (err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 1'b1;
                if (err_cnt_q == 8'h00) ff_adr_q <= adr_q;
            end
        end
    end

    assign adr_i                     = adr_q;
    assign reg_write_en              = (state_q == WR);
    assign reg_read_en               = (state_q == RD);
    assign data_i                    = data_q;
    assign command_complete          = cmd_q;
    assign response_i                = resp_q;
    assign error_interrupt_status_i  = err_stat_q;
    assign normal_interrupt_status_i = norm_stat_q;
    assign busy                      = (state_q != IDLE);
    assign done                      = (state_q == FIN);
    assign err_count                 = err_cnt_q;
    assign first_fail_adr            = ff_adr_q;

endmodule

// File: doc/reg_stim_sequencer.md
# reg_stim_sequencer

Parametrised, synthesizable stimulus sequencer for the SD host register file. It replaces free-running time-based generators with a clocked FSM. It sweeps an address range with write, read or write-then-read-back passes, and regenerates write data deterministically so read-back can be self-checked. It emits command-complete/response/interrupt-status stimulus tied to accesses of the command register. It sits between the bench top and the register file DUT and also runs on FPGA bring-up builds.

## Interface
Parameters:
- ADR_W, 5, address width
- DATA_W, 128, data and response width
- STAT_W, 16, interrupt status width
- ADR_FIRST, 0, first swept address
- ADR_LAST, 15, last swept address (≥ ADR_FIRST)
- CMD_ADR, 15, address whose write counts as a command
- GAP, 2, idle cycles after each access (0 allowed)
- DATA_STEP, 2, data increment per address
- RESP_STEP, 128'ha3157934b95c7a64789213fd456e, response increment per command
- ERR_STEP, 7, error status increment per command
- NORM_STEP, 9, normal status increment per command

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin a run (sampled in IDLE only)
- stop  in  1  end the run after the current access
- mode  in  2  00 write sweep, 01 read sweep, 10 write then read-back, 11 mode-10 looped
- rd_data_i  in  DATA_W  register file read data, valid 1 cycle after reg_read_en
- adr_i  out  ADR_W  access address
- reg_write_en  out  1  write strobe
- reg_read_en  out  1  read strobe
- data_i  out  DATA_W  write data
- command_complete  out  1  1-cycle pulse
- response_i  out  DATA_W  response stimulus
- error_interrupt_status_i  out  STAT_W  error status stimulus
- normal_interrupt_status_i  out  STAT_W  normal status stimulus
- busy  out  1  run in progress
- done  out  1  1-cycle pulse at the end of a run
- err_count  out  8  read-back mismatches, saturating at 255
- first_fail_adr  out  ADR_W  address of the first mismatch in the run

## Operation
- FSM states: IDLE, WR, WGAP, RD, RWAIT, RGAP, FIN.
- IDLE → WR on start (modes 00/10/11), or IDLE → RD on start (mode 01).
  - Mode is latched at start.
  - seed and err_count are cleared at start; first_fail_adr holds until the first mismatch.
- WR: assert reg_write_en for 1 cycle.
  - adr_i = current address.
  - data_i = seed + adr·DATA_STEP, truncated to DATA_W.
- WGAP: hold for GAP cycles, then advance the address.
  - At ADR_LAST, the write phase ends: mode 00 → FIN, modes 10/11 → RD at ADR_FIRST.
  - Otherwise → WR.
- RD: assert reg_read_en for 1 cycle, then RWAIT.
- RWAIT: compare rd_data_i against the expected value (modes 10/11 only).
  - Expected value uses the same formula as write data.
  - On mismatch: err_count+1; first_fail_adr is captured if err_count was 0.
- RGAP: hold for GAP cycles, then advance the address.
  - At ADR_LAST: mode 11 → seed+1 and go to WR at ADR_FIRST; other modes → FIN.
- FIN: pulse done for 1 cycle, then → IDLE. busy = 1 in every state except IDLE.
- Command event: a WR at CMD_ADR, or an RD at CMD_ADR in mode 01.
  - Pulses command_complete on the following cycle.
  - On that same cycle: response_i += RESP_STEP, error status += ERR_STEP, normal status += NORM_STEP.
  - All these counters wrap modulo 2^width.
- stop is sticky until consumed.
  - When the current access and its GAP finish, go to FIN, also mid-pass.
  - In RWAIT, the compare still happens before the stop takes effect.
- Ignored inputs: start while busy is ignored, and stop in IDLE is ignored. start and stop asserted together in IDLE start the run and end it after the first access.
- Address counter wraps within ADR_FIRST..ADR_LAST only.

## Timing
- Reset values: all outputs 0, adr_i = ADR_FIRST, state IDLE.
- Reset mid-run forces IDLE on the next evaluation. No done pulse is produced, and all stimulus counters are cleared.
- start sampled at edge t → first strobe high during cycle t+1.
- Cycle cost per access:
  - write: 1+GAP cycles
  - read: 2+GAP cycles
- Run length:
  - mode 00: N·(1+GAP) cycles, then 1 cycle of done.
  - mode 10: N·(3+2·GAP) cycles, then 1 cycle of done.
  - N = ADR_LAST−ADR_FIRST+1.
- adr_i/data_i change only on the strobe cycle and hold through the gap.
- At most one strobe is high in any cycle.
- command_complete is never high on two consecutive cycles, even when GAP=0.

## Test plan
- Reset during a mode-10 run at adr 6 → all outputs 0 and busy=0 on the next cycle; a fresh start → data_i=0 at adr 0.
- Mode 00, defaults, start at cycle 0:
  - writes occur at cycles 1,4,…,46; adr 5 carries data 10.
  - command_complete at cycle 47 with response_i=RESP_STEP, error status 7, normal status 9.
  - done at cycle 49.
- Mode 10 with an echoing register model → err_count=0. Corrupting bit 0 of adr 7 → err_count=1, first_fail_adr=7.
- Mode 11 for 3 passes, then stop during the pass-4 write of adr 2:
  - adr 2 data = 3+4 = 7.
  - stop → FIN after that access's gap (done 3 cycles after the write strobe); command_complete count = 3.
- start pulsed while busy → no restart, and run length is unchanged. start and stop together in IDLE → exactly one write at ADR_FIRST, then done.
- STAT_W=4, 3 commands → error status 21 mod 16 = 5, normal status 27 mod 16 = 11. GAP=0 → strobes on consecutive cycles and no dropped compares.
